// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the bit-serial adder controller
// Contents: controller state encoding and the default operand width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational 1-bit full adder cell
// Ports: A, B, Cin (in, 1 bit each); Sum, Cout (out, 1 bit each).
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller around one full_adder cell
// Ports: clk, rst (sync, active-high); start, A, B, Cin request inputs;
//        busy (RUN), done (1-cycle pulse), Sum/Cout registered result.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum, fa_cout;
  logic             accept, last;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // DONE accepts a new request just like IDLE so back-to-back adds have no bubble.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (count == CW'(WIDTH - 1));

  // Result bits arrive LSB first, so each new bit enters at the MSB end.
  always_comb begin
    res_nx            = res_sr >> 1;
    res_nx[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      Sum    <= '0;
      Cout   <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nx;
      carry  <= fa_cout;
      count  <= count + 1'b1;
      // Outputs only move on the final bit so they hold the previous result during RUN.
      if (last) begin
        Sum  <= res_nx;
        Cout <= fa_cout;
      end
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      count <= '0;
    end
  end

endmodule
